// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter in front of a shared immediate-extension unit
// (sext8 / sext11 / zext8) with a single registered, stallable output stage.
module imm_ext_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [2*NREQ-1:0]         req_mode,
   input  logic [11*NREQ-1:0]        req_imm,
   output logic [NREQ-1:0]           req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_data,
   output logic [$clog2(NREQ)-1:0]   out_slot,
   output logic                      out_err
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      MODE_SEXT8   = 2'b00,
      MODE_SEXT11  = 2'b01,
      MODE_ZEXT8   = 2'b10,
      MODE_ILLEGAL = 2'b11
   } mode_e;

   logic [IW-1:0] rr_q, rr_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_data_q, out_data_d;
   logic [IW-1:0] out_slot_q, out_slot_d;
   logic          out_err_q, out_err_d;

   logic          out_free;
   logic          grant_found;
   logic          transfer;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] cand;
   logic [1:0]    mode_a [NREQ];
   logic [10:0]   imm_a  [NREQ];
   mode_e         grant_mode;
   logic [10:0]   grant_imm;
   logic [31:0]   ext_data;
   logic          ext_err;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         mode_a[i] = req_mode[2*i +: 2];
         imm_a[i]  = req_imm[11*i +: 11];
      end
   end

   assign out_free = !out_valid_q || out_ready;

   // NREQ is a power of two, so the IW-bit add wraps the search index for free.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = rr_q + IW'(i);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign transfer  = grant_found && out_free && !reset;
   assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

   assign grant_mode = mode_e'(mode_a[grant_idx]);
   assign grant_imm  = imm_a[grant_idx];

   always_comb begin
      ext_data = '0;
      ext_err  = 1'b0;
      case (grant_mode)
         MODE_SEXT8:  ext_data = {{24{grant_imm[7]}}, grant_imm[7:0]};
         MODE_SEXT11: ext_data = {{21{grant_imm[10]}}, grant_imm};
         MODE_ZEXT8:  ext_data = {24'h0, grant_imm[7:0]};
         default:     ext_err  = 1'b1;
      endcase
   end

   always_comb begin
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_slot_d  = out_slot_q;
      out_err_d   = out_err_q;
      if (transfer) begin
         rr_d        = grant_idx + IW'(1);
         out_valid_d = 1'b1;
         out_data_d  = ext_data;
         out_slot_d  = grant_idx;
         out_err_d   = ext_err;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_slot_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_slot_q  <= out_slot_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_slot  = out_slot_q;
   assign out_err   = out_err_q;

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Purpose: shares one immediate-extension unit (sign-extend 8->32, sign-extend 11->32, zero-extend 8->32) among the VLIW issue slots. Round-robin grant, valid/ready handshake, one registered output stage.

Interface
REQ-001 Parameter: NREQ, 4, number of requesting issue slots; SHALL be a power of two in 2..8.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  NREQ  bit i set means slot i presents an extension request.
REQ-005 Port: req_mode  input  2*NREQ  slot i mode at [2i+1:2i]: 00 sext8, 01 sext11, 10 zext8, 11 illegal.
REQ-006 Port: req_imm  input  11*NREQ  slot i raw immediate at [11i+10:11i].
REQ-007 Port: req_ready  output  NREQ  one-hot-or-zero grant; slot i request consumed when req_valid[i] & req_ready[i].
REQ-008 Port: out_valid  output  1  result register holds a valid result.
REQ-009 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-010 Port: out_data  output  32  extended immediate.
REQ-011 Port: out_slot  output  log2(NREQ)  index of the slot that produced out_data.
REQ-012 Port: out_err  output  1  result came from illegal mode 11.

Function
REQ-013 Output stage "free" SHALL mean (!out_valid) | out_ready.
REQ-014 req_ready SHALL be combinational: zero when output stage not free; otherwise exactly one bit set, for the first slot with req_valid set, searching upward from rr_ptr with wrap from NREQ-1 to 0.
REQ-015 req_ready SHALL be zero when no req_valid bit is set.
REQ-016 rr_ptr (log2(NREQ) bits) SHALL advance to (granted index + 1) mod NREQ on each transfer and SHALL hold otherwise.
REQ-017 On a transfer from slot k, the next edge SHALL load out_valid=1, out_slot=k, and out_data/out_err from slot k's mode and immediate; latency is one cycle.
REQ-018 Mode 00: out_data = 24 copies of imm[7], then imm[7:0]; out_err=0.
REQ-019 Mode 01: out_data = 21 copies of imm[10], then imm[10:0]; out_err=0. Sign source SHALL be bit 10.
REQ-020 Mode 10: out_data = 24 zeros, then imm[7:0]; out_err=0.
REQ-021 Mode 11: out_data = 0 and out_err=1; the request is still consumed, and rr_ptr advances normally.
REQ-022 Bits of req_imm above the mode's source width SHALL be ignored.
REQ-023 When out_valid & out_ready and no transfer occurs on the same edge, out_valid SHALL clear; out_data, out_slot and out_err SHALL hold their last values.
REQ-024 When out_valid & !out_ready, out_valid, out_data, out_slot, out_err and rr_ptr SHALL all hold (stall).
REQ-025 When out_valid & out_ready and a transfer occurs on the same edge, the new result SHALL replace the old one with no bubble, giving full throughput of one result per cycle.
REQ-026 A slot that drops req_valid before being granted SHALL NOT be granted.
REQ-027 No slot SHALL wait more than NREQ-1 transfers while continuously valid.

Reset
REQ-028 While reset is high, the block SHALL asynchronously force out_valid=0, out_data=0, out_slot=0, out_err=0 and rr_ptr=0.
REQ-029 req_ready SHALL be all-zero while reset is high.
REQ-030 A result pending at reset assertion SHALL be discarded.
REQ-031 The first grant after reset release SHALL use priority starting at slot 0.

Verification
REQ-032 Reset, then slot 2 only: mode 00, imm 0x080 -> req_ready=0100; next cycle out_valid=1, out_slot=2, out_data=0xFFFFFF80, out_err=0.
REQ-033 Slot 1: mode 01, imm 0x400 -> out_data=0xFFFFFC00. Slot 1: mode 01, imm 0x3FF -> out_data=0x000003FF. Slot 0: mode 10, imm 0x7F5 -> out_data=0x000000F5.
REQ-034 All four slots valid continuously, out_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles, with one out_valid result per cycle and out_slot following the grants.
REQ-035 out_ready=0 for 3 cycles with a result pending -> req_ready=0, outputs and rr_ptr stable throughout; the next grant follows immediately once out_ready=1.
REQ-036 Mode 11 request from slot 3 -> out_err=1, out_data=0, rr_ptr becomes 0.
REQ-037 Reset asserted mid-stream with out_valid=1 -> all outputs zero immediately without a clock edge; after release, slot 0 wins over slot 1 when both are valid.
